binary_conv3x3: RTL and testbench
=================================

# binary_conv3x3

Streaming 3x3 binary convolution stage for the binarized MNIST datapath. Accepts one 1-bit pixel per cycle in raster order and applies a fixed 3x3 binary kernel using XNOR and popcount. It emits one thresholded 1-bit feature pixel per valid (IMG_W-2)x(IMG_H-2) window. Sits directly upstream of max_pooling: conv_out/valid_out_conv drive its pixel_in/valid_in.

## Interface
- IMG_W, 28: input image width in pixels (>= 3)
- IMG_H, 28: input image height in pixels (>= 3)
- THRESH, 5: popcount threshold; conv_out = 1 when match count >= THRESH (range 0..9)
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  pixel_in is valid this cycle
- pixel_in  in  1  input pixel, raster order, row-major
- weights  in  9  kernel; bit r*3+c is the weight at window row r (0 = top), column c (0 = left); held static during a frame
- conv_out  out  1  thresholded convolution result
- valid_out_conv  out  1  one-cycle strobe qualifying conv_out

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on cycles with valid_in=1.
- col wraps to 0 at IMG_W-1 and increments row. row wraps to 0 after (IMG_H-1, IMG_W-1), so the next accepted pixel starts a new frame. No idle gap is required between frames.
- Two IMG_W-deep 1-bit line buffers hold rows row-1 and row-2. On each accepted pixel, the 3-bit column {row-2, row-1, row} at position col shifts into a 3x3 window register. The line buffers are updated at col.
- A window is complete when the accepted pixel has row >= 2 and col >= 2. Its top-left corner is then (row-2, col-2).
- Match count = popcount(~(window ^ weights)), a 4-bit value in 0..9.
- For a complete window: conv_out <= (count >= THRESH), valid_out_conv <= 1.
- For any other cycle (incomplete window or valid_in=0): valid_out_conv <= 0, and conv_out holds its last value.
- Exactly (IMG_W-2)*(IMG_H-2) strobes per frame (676 at default), in raster order of output position.
- Windows never span a row wrap. Columns 0 and 1 of each row only prime the window.
- Line buffer contents are not reset. Stale data is never observable, because output is gated by the row >= 2 and col >= 2 condition.

## Timing
- Reset values: conv_out=0, valid_out_conv=0, row=0, col=0, window=0.
- Reset is asynchronous and takes effect immediately, including mid-frame. The first accepted pixel after rst deasserts is treated as (0,0).
- Latency: the strobe appears 1 cycle after the rising edge that accepts the window-completing pixel.
- valid_in low (bubbles): counters, window and buffers hold. Output sequence is identical to the gapless case, only delayed.
- No backpressure; the downstream stage must accept every strobe.
- weights changes mid-frame take effect on the next computed window; this is not supported functionally.

## Configuration
- BIN_CONV_POPCNT_OUT_EN:
  - When defined, adds output port popcount_out (out, 4 bits). It is the registered match count, updated on the same edge and with the same reset (0) and hold rules as conv_out.
  - When undefined, the port and its register are absent; conv_out behaviour is unchanged.

## Test plan
- All-zero 28x28 frame, weights=9'b000000000, THRESH=5:
  - 676 strobes, all conv_out=1.
  - First strobe 1 cycle after input index 58 (row 2, col 2).
- All-ones frame, weights=0: 676 strobes, all conv_out=0 (count 0).
- Checkerboard pixel (i+j)%2, weights=9'b101010101: the output at window top-left (y,x) is (y+x)%2, i.e. a 26x26 checkerboard.
  - Count is 9 or 0; also check popcount_out when BIN_CONV_POPCNT_OUT_EN is defined.
- Checkerboard frame with valid_in deasserted on every third cycle:
  - The conv_out sequence is identical to the gapless run.
  - No strobe occurs in the cycle following a bubble cycle.
- Assert rst for 1 cycle after 100 accepted pixels, then stream a full all-zero frame:
  - conv_out and valid_out_conv are 0 immediately on reset.
  - Exactly 676 strobes follow, all 1.
- Two back-to-back frames (all-ones then all-zero, weights=0):
  - 676 zeros, then 676 ones.
  - The first strobe of frame 2 follows its pixel index 58, with no cross-frame windows.

Source files
------------

// File: rtl/binary_conv3x3_if.sv
// Pixel-stream bundle between a binary_conv3x3 stage and its producer/consumer.
// popcount_out exists only when BIN_CONV_POPCNT_OUT_EN is defined.
interface binary_conv3x3_if;
    logic       valid_in;
    logic       pixel_in;
    logic [8:0] weights;
    logic       conv_out;
    logic       valid_out_conv;
`ifdef BIN_CONV_POPCNT_OUT_EN
    logic [3:0] popcount_out;

    modport master (
        output valid_in, pixel_in, weights,
        input  conv_out, valid_out_conv, popcount_out
    );
    modport slave (
        input  valid_in, pixel_in, weights,
        output conv_out, valid_out_conv, popcount_out
    );
`else
    modport master (
        output valid_in, pixel_in, weights,
        input  conv_out, valid_out_conv
    );
    modport slave (
        input  valid_in, pixel_in, weights,
        output conv_out, valid_out_conv
    );
`endif
endinterface

// File: rtl/binary_conv3x3.sv
// binary_conv3x3: streaming 3x3 XNOR/popcount binary convolution with threshold; BIN_CONV_POPCNT_OUT_EN adds popcount_out.
// Latency: strobe one cycle after the edge that accepts the window-completing pixel.
// Backpressure: none; valid_in bubbles freeze counters, window and line buffers, downstream takes every strobe.
module binary_conv3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int THRESH = 5
) (
    input  logic              clk,
    input  logic              rst,
    binary_conv3x3_if.slave   bus
);
    localparam int         CW  = $clog2(IMG_W);
    localparam int         RW  = $clog2(IMG_H);
    localparam logic [3:0] THR = 4'(THRESH);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [IMG_W-1:0] lb1;
    logic [IMG_W-1:0] lb2;
    // Two newest columns of the previous window; the oldest column is dropped on each shift.
    logic [5:0]       hist;
    logic [5:0]       hist_nxt;
    logic [2:0]       new_col;
    logic [8:0]       win_nxt;
    logic [8:0]       match;
    logic [3:0]       cnt;
    logic             col_last;
    logic             row_last;
    logic             complete;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign complete = bus.valid_in && (row >= RW'(2)) && (col >= CW'(2));

    // Window row 0 is the oldest image row (row-2), row 2 the current one.
    assign new_col = {bus.pixel_in, lb1[col], lb2[col]};

    always_comb begin
        win_nxt  = '0;
        hist_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[r*3+0]  = hist[r*2+0];
            win_nxt[r*3+1]  = hist[r*2+1];
            win_nxt[r*3+2]  = new_col[r];
            hist_nxt[r*2+0] = win_nxt[r*3+1];
            hist_nxt[r*2+1] = win_nxt[r*3+2];
        end
    end

    always_comb begin
        match = ~(win_nxt ^ bus.weights);
        cnt   = '0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'b000, match[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            hist <= '0;
        end else if (bus.valid_in) begin
            hist <= hist_nxt;
            col  <= col_last ? '0 : col + CW'(1);
            if (col_last) begin
                row <= row_last ? '0 : row + RW'(1);
            end
        end
    end

    // Line buffers are not reset: outputs are gated until two full rows have passed.
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            lb2[col] <= lb1[col];
            lb1[col] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.conv_out       <= 1'b0;
            bus.valid_out_conv <= 1'b0;
        end else begin
            bus.valid_out_conv <= complete;
            if (complete) begin
                bus.conv_out <= (cnt >= THR);
            end
        end
    end

`ifdef BIN_CONV_POPCNT_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.popcount_out <= 4'd0;
        end else if (complete) begin
            bus.popcount_out <= cnt;
        end
    end
`endif
endmodule

// File: tb/tb_binary_conv3x3.sv
// Bench for binary_conv3x3: pattern table, random frames, mid-frame reset and back-to-back frames
// checked against a window-by-window reference computed from the frame image.
module tb_binary_conv3x3;
    localparam int W = 28;
    localparam int H = 28;
    localparam int T = 5;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    binary_conv3x3_if bus ();

    binary_conv3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         pat;
        logic [8:0] w;
        int         bmode;
        int         exp_strobes;
        int         exp_ones;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   img [H][W];
    bit   exp_out [$];
    int   exp_cnt [$];
    bit   got_out [$];
    int   got_cnt [$];
    int   timing_err = 0;
    bit   exp_strobe = 1'b0;
    bit   last_out = 1'b0;
    int   pix_idx = 0;
    int   cyc = 0;

    function automatic void chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Output monitor: strobe timing follows the accepted-pixel position, conv_out holds between strobes.
    always @(negedge clk) begin
        if (rst) begin
            exp_strobe = 1'b0;
            pix_idx    = 0;
            last_out   = 1'b0;
        end else begin
            if (bus.valid_out_conv !== exp_strobe) timing_err++;
            if (bus.valid_out_conv === 1'b1) begin
                got_out.push_back(bus.conv_out);
`ifdef BIN_CONV_POPCNT_OUT_EN
                got_cnt.push_back(int'(bus.popcount_out));
`else
                got_cnt.push_back(-1);
`endif
                last_out = bus.conv_out;
            end else if (bus.conv_out !== last_out) begin
                timing_err++;
            end
            if (bus.valid_in) begin
                exp_strobe = (pix_idx / W >= 2) && (pix_idx % W >= 2);
                pix_idx    = (pix_idx + 1) % N;
            end else begin
                exp_strobe = 1'b0;
            end
        end
    end

    task automatic fill(input int pat);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (pat)
                    0:       img[y][x] = 1'b0;
                    1:       img[y][x] = 1'b1;
                    2:       img[y][x] = bit'((y + x) % 2);
                    default: img[y][x] = bit'($urandom_range(0, 1));
                endcase
    endtask

    task automatic model_append(input logic [8:0] w);
        for (int y = 0; y <= H - 3; y++)
            for (int x = 0; x <= W - 3; x++) begin
                int c = 0;
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        if (img[y+r][x+k] == w[r*3+k]) c++;
                exp_out.push_back(c >= T);
                exp_cnt.push_back(c);
            end
    endtask

    // bmode 0: gapless, 1: every third cycle idle, 2: random idles.
    task automatic drive_pixels(input int n, input int bmode);
        int p = 0;
        while (p < n) begin
            @(posedge clk); #1;
            if ((bmode == 1 && cyc % 3 == 2) || (bmode == 2 && $urandom_range(0, 2) == 0)) begin
                bus.valid_in = 1'b0;
            end else begin
                bus.valid_in = 1'b1;
                bus.pixel_in = img[p / W][p % W];
                p++;
            end
            cyc++;
        end
    endtask

    task automatic idle_drain();
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        exp_out.delete();
        exp_cnt.delete();
        got_out.delete();
        got_cnt.delete();
        timing_err = 0;
    endtask

    task automatic check_model(input string name);
        int bad = 0;
        int m;
        chk({name, " strobe count vs model"}, got_out.size(), exp_out.size());
        m = (got_out.size() < exp_out.size()) ? got_out.size() : exp_out.size();
        for (int i = 0; i < m; i++) begin
            if (got_out[i] != exp_out[i]) bad++;
`ifdef BIN_CONV_POPCNT_OUT_EN
            if (got_cnt[i] != exp_cnt[i]) bad++;
`endif
        end
        chk({name, " values vs model (bad entries)"}, bad, 0);
        chk({name, " strobe timing/hold errors"}, timing_err, 0);
    endtask

    vec_t tbl [5];

    initial begin
        logic [8:0] w;
        int ones;

        tbl[0] = '{0, 9'h000, 0, 676, 676};
        tbl[1] = '{1, 9'h000, 0, 676, 0};
        tbl[2] = '{2, 9'h155, 0, 676, 338};
        tbl[3] = '{2, 9'h155, 1, 676, 338};
        tbl[4] = '{0, 9'h1FF, 2, 676, 0};

        bus.valid_in = 1'b0;
        bus.pixel_in = 1'b0;
        bus.weights  = 9'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset conv_out", int'(bus.conv_out), 0);
        chk("reset valid_out_conv", int'(bus.valid_out_conv), 0);
`ifdef BIN_CONV_POPCNT_OUT_EN
        chk("reset popcount_out", int'(bus.popcount_out), 0);
`endif
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            start_run();
            fill(tbl[t].pat);
            bus.weights = tbl[t].w;
            model_append(tbl[t].w);
            drive_pixels(N, tbl[t].bmode);
            idle_drain();
            ones = 0;
            foreach (got_out[i]) if (got_out[i]) ones++;
            chk($sformatf("vec%0d strobe count", t), got_out.size(), tbl[t].exp_strobes);
            chk($sformatf("vec%0d ones count", t), ones, tbl[t].exp_ones);
            check_model($sformatf("vec%0d", t));
        end

        for (int k = 0; k < 3; k++) begin
            start_run();
            fill(3);
            w = 9'($urandom);
            bus.weights = w;
            model_append(w);
            drive_pixels(N, 2);
            idle_drain();
            check_model($sformatf("rand%0d", k));
        end

        // Mid-frame reset after 100 accepted pixels.
        start_run();
        fill(0);
        bus.weights = 9'h000;
        drive_pixels(100, 0);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("midframe reset conv_out", int'(bus.conv_out), 0);
        chk("midframe reset valid_out_conv", int'(bus.valid_out_conv), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_run();
        model_append(9'h000);
        drive_pixels(N, 0);
        idle_drain();
        ones = 0;
        foreach (got_out[i]) if (got_out[i]) ones++;
        chk("after reset ones count", ones, 676);
        check_model("after reset");

        // Back-to-back frames with no idle cycle between them.
        start_run();
        bus.weights = 9'h000;
        fill(1);
        model_append(9'h000);
        drive_pixels(N, 0);
        fill(0);
        model_append(9'h000);
        drive_pixels(N, 0);
        idle_drain();
        chk("b2b total strobes", got_out.size(), 2 * 676);
        check_model("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
